// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload on period boundaries.
// Optional build macro FREQ_DIV_DUTY_EN adds a programmable high time (duty_val / cur_duty).
module freq_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
`ifdef FREQ_DIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_val,
    output logic [WIDTH-1:0] cur_duty,
`endif
    output logic             div_ack,
    output logic [WIDTH-1:0] cur_div,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV >> 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] pend_div;
    logic             pend;

    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] sel_div;
    logic [WIDTH-1:0] new_d;
    logic [WIDTH-1:0] new_h;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] nxt_h;
    logic [WIDTH-1:0] nxt_cnt;

`ifdef FREQ_DIV_DUTY_EN
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] sel_duty;
`endif

    always_comb begin
        wrap    = (cnt == d - ONE);
        apply   = div_load | pend;
        // A load arriving on the wrap cycle bypasses the pending register.
        sel_div = div_load ? div_val : pend_div;
        new_d   = (sel_div < TWO) ? TWO : sel_div;
`ifdef FREQ_DIV_DUTY_EN
        h        = h_q;
        sel_duty = div_load ? duty_val : pend_duty;
        if (sel_duty == '0)
            new_h = ONE;
        else if (sel_duty > new_d - ONE)
            new_h = new_d - ONE;
        else
            new_h = sel_duty;
`else
        h     = d >> 1;
        new_h = new_d >> 1;
`endif
        nxt_d   = (wrap && apply) ? new_d : d;
        nxt_h   = (wrap && apply) ? new_h : h;
        nxt_cnt = wrap ? '0 : cnt + ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            d        <= DEF_D;
            pend     <= 1'b0;
            pend_div <= '0;
            clk_div  <= 1'b0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
            h_q       <= DEF_H;
            pend_duty <= '0;
`endif
        end else begin
            if (en) begin
                cnt     <= nxt_cnt;
                d       <= nxt_d;
                // Registered from next-state values so clk_div lines up with cnt.
                clk_div <= (nxt_cnt >= nxt_d - nxt_h);
                tick    <= wrap;
                div_ack <= wrap && apply;
`ifdef FREQ_DIV_DUTY_EN
                h_q     <= nxt_h;
`endif
            end else begin
                tick    <= 1'b0;
                div_ack <= 1'b0;
            end
            if (en && wrap) begin
                pend <= 1'b0;
            end else if (div_load) begin
                pend     <= 1'b1;
                pend_div <= div_val;
`ifdef FREQ_DIV_DUTY_EN
                pend_duty <= duty_val;
`endif
            end
        end
    end

    assign cur_div = d;
`ifdef FREQ_DIV_DUTY_EN
    assign cur_duty = h_q;
`else
    logic unused_h;
    assign unused_h = ^{DEF_H, h};
`endif

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog: a cycle model feeds an expected queue that is checked every cycle,
// plus waveform-level checks (tick counts, high-time counts, active divisor) per scenario.
module tb_freq_div_prog;
  localparam int W   = 16;
  localparam int DEF = 10;
  localparam int VW  = 2 * W + 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic div_ack;
  logic [W-1:0] cur_div;
  logic clk_div;
  logic tick;
`ifdef FREQ_DIV_DUTY_EN
  logic [W-1:0] duty_val = '0;
  logic [W-1:0] cur_duty;
`endif

  freq_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .div_val(div_val),
    .div_load(div_load),
`ifdef FREQ_DIV_DUTY_EN
    .duty_val(duty_val),
    .cur_duty(cur_duty),
`endif
    .div_ack(div_ack),
    .cur_div(cur_div),
    .clk_div(clk_div),
    .tick(tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int step_no = 0;
  int n_tick = 0;
  int n_high = 0;
  int n_ack = 0;

  // scoreboard: {clk_div, tick, div_ack, cur_div, cur_duty}
  logic [VW-1:0] exp_q[$];

  // reference model state
  int m_cnt = 0;
  int m_d = DEF;
  int m_h = DEF / 2;
  int m_pv = 0;
  int m_pdu = 0;
  bit m_pend = 0;
  bit m_cd = 0;
  bit m_tk = 0;
  bit m_ack = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit l, input int v, input int du);
    bit wrap;
    bit apply;
    int sv;
    if (!r) begin
      m_cnt = 0; m_d = DEF; m_h = DEF / 2; m_pend = 0;
      m_cd = 0; m_tk = 0; m_ack = 0;
    end else if (!e) begin
      m_tk = 0; m_ack = 0;
      if (l) begin m_pend = 1; m_pv = v; m_pdu = du; end
    end else begin
      wrap = (m_cnt == m_d - 1);
      if (wrap) begin
        apply = l || m_pend;
        sv = l ? v : m_pv;
        if (apply) begin
          m_d = (sv < 2) ? 2 : sv;
`ifdef FREQ_DIV_DUTY_EN
          begin
            int sdu;
            sdu = l ? du : m_pdu;
            m_h = (sdu == 0) ? 1 : ((sdu > m_d - 1) ? m_d - 1 : sdu);
          end
`endif
        end
        m_ack = apply; m_pend = 0; m_cnt = 0;
      end else begin
        m_ack = 0;
        if (l) begin m_pend = 1; m_pv = v; m_pdu = du; end
        m_cnt++;
      end
      m_tk = wrap;
`ifndef FREQ_DIV_DUTY_EN
      m_h = m_d / 2;
`endif
      m_cd = (m_cnt >= m_d - m_h);
    end
  endtask

  // driver: one clock cycle of stimulus, model update, and output comparison
  task automatic step(input bit r, input bit e, input bit l, input int v, input int du);
    logic [VW-1:0] exp_v;
    logic [VW-1:0] obs_v;
    @(negedge clk);
    reset = r; en = e; div_load = l; div_val = W'(v);
`ifdef FREQ_DIV_DUTY_EN
    duty_val = W'(du);
`endif
    model(r, e, l, v, du);
`ifdef FREQ_DIV_DUTY_EN
    exp_q.push_back({m_cd, m_tk, m_ack, W'(m_d), W'(m_h)});
`else
    exp_q.push_back({m_cd, m_tk, m_ack, W'(m_d), W'(0)});
`endif
    @(posedge clk);
    #1;
    step_no++;
    exp_v = exp_q.pop_front();
`ifdef FREQ_DIV_DUTY_EN
    obs_v = {clk_div, tick, div_ack, cur_div, cur_duty};
`else
    obs_v = {clk_div, tick, div_ack, cur_div, W'(0)};
`endif
    tests_run++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL cycle%0d observed=%h expected=%h", step_no, obs_v, exp_v);
    end
    n_tick += int'(tick);
    n_high += int'(clk_div);
    n_ack += int'(div_ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
  endtask

  // advance until the next enabled cycle will wrap
  task automatic run_to_wrap();
    int budget;
    budget = 0;
    while (m_cnt != m_d - 1 && budget < 200) begin
      step(1, 1, 0, 0, 0);
      budget++;
    end
    if (budget >= 200) check("wrap_timeout", budget, 0);
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 0);
    check("rst_cur_div", int'(cur_div), 10);
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_tick", int'(tick), 0);

    // default divide-by-10
    n_tick = 0; n_high = 0;
    idle(30);
    check("t1_ticks", n_tick, 3);
    check("t1_high", n_high, 15);
    check("t1_tick30", int'(tick), 1);
    check("t1_cur_div", int'(cur_div), 10);

    // load 4 mid-period
    n_ack = 0;
    idle(3);
    step(1, 1, 1, 4, 0);
    idle(5);
    check("t2_old_div", int'(cur_div), 10);
    step(1, 1, 0, 0, 0);
    check("t2_tick", int'(tick), 1);
    check("t2_ack", int'(div_ack), 1);
    check("t2_cur_div", int'(cur_div), 4);
    n_tick = 0; n_high = 0;
    idle(8);
    check("t2_ticks", n_tick, 2);
    check("t2_high", n_high, 4);
    check("t2_acks", n_ack, 1);

    // last load wins, then load on the wrap cycle
    step(1, 1, 1, 7, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 5, 0);
    n_ack = 0;
    run_to_wrap();
    step(1, 1, 0, 0, 0);
    check("t3_cur_div5", int'(cur_div), 5);
    check("t3_acks", n_ack, 1);
    run_to_wrap();
    step(1, 1, 1, 7, 0);
    check("t3_bypass_div", int'(cur_div), 7);
    check("t3_bypass_ack", int'(div_ack), 1);
    n_tick = 0; n_high = 0;
    idle(7);
    check("t3_high", n_high, 3);
    check("t3_ticks", n_tick, 1);

    // load 0 clamps to 2
    step(1, 1, 1, 0, 0);
    run_to_wrap();
    step(1, 1, 0, 0, 0);
    check("t4_cur_div", int'(cur_div), 2);
    n_tick = 0; n_high = 0;
    idle(8);
    check("t4_ticks", n_tick, 4);
    check("t4_high", n_high, 4);

    // enable low mid-period, then reset with a load pending
    step(1, 1, 1, 6, 0);
    run_to_wrap();
    step(1, 1, 0, 0, 0);
    idle(2);
    n_tick = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 9, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check("t5_frozen_ticks", n_tick, 0);
    check("t5_frozen_div", int'(cur_div), 6);
    idle(3);
    check("t5_no_early_tick", int'(tick), 0);
    step(1, 1, 0, 0, 0);
    check("t5_resume_tick", int'(tick), 1);
    check("t5_cur_div9", int'(cur_div), 9);
    step(1, 1, 1, 3, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("t5_rst_clk_div", int'(clk_div), 0);
    check("t5_rst_tick", int'(tick), 0);
    check("t5_rst_cur_div", int'(cur_div), 10);
    n_ack = 0;
    idle(12);
    check("t5_discarded_ack", n_ack, 0);
    check("t5_after_rst_div", int'(cur_div), 10);

`ifdef FREQ_DIV_DUTY_EN
    // programmable high time
    step(1, 1, 1, 10, 3);
    run_to_wrap();
    step(1, 1, 0, 0, 0);
    check("t6_duty3", int'(cur_duty), 3);
    n_high = 0;
    idle(10);
    check("t6_high3", n_high, 3);
    step(1, 1, 1, 8, 15);
    run_to_wrap();
    step(1, 1, 0, 0, 0);
    check("t6_duty_clamp", int'(cur_duty), 7);
    check("t6_div8", int'(cur_div), 8);
    n_high = 0;
    idle(8);
    check("t6_high7", n_high, 7);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
